alu_reg_unit: RTL and testbench

- Multicycle-MIPS execution primitive set packaged as one block.
- Contains a combinational ALU with result and zero flag, plus an ALUOut register that loads every cycle (flopr behaviour).
- Contains a general enabled register (flopenr behaviour) used for PC/IR-style state.
- Sits in the datapath between the SrcA/SrcB muxes and the PC/writeback muxes.

---
 rtl/mips_pkg.sv | 12 +
 rtl/alu_reg_unit_if.sv | 25 ++
 rtl/alu_reg_unit_alu_core.sv | 36 +++
 rtl/alu_reg_unit.sv | 40 ++++
 tb/tb_alu_reg_unit.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU operation encodings driven by the
// ALU decoder onto alucontrol.
package mips_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

endpackage

// File: rtl/alu_reg_unit_if.sv
// Operand, result and enabled-register signals of alu_reg_unit, grouped as
// one bundle; master drives operands/controls, slave is the unit itself.
interface alu_reg_unit_if #(parameter int WIDTH = 32);

   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic [3:0]       alucontrol;
   logic [WIDTH-1:0] aluresult;
   logic             zero;
   logic [WIDTH-1:0] aluout;
   logic             en;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (
      output srca, srcb, alucontrol, en, d,
      input  aluresult, zero, aluout, q
   );

   modport slave (
      input  srca, srcb, alucontrol, en, d,
      output aluresult, zero, aluout, q
   );

endinterface

// File: rtl/alu_reg_unit_alu_core.sv
// Combinational ALU with zero detect; unlisted opcodes yield a defined 0.
module alu_core
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alucontrol,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   logic slt_bit;
   logic sltu_bit;

   // Direct signed compare stays correct where a-b would overflow.
   assign slt_bit  = $signed(a) < $signed(b);
   assign sltu_bit = a < b;

   always_comb begin
      result = '0;
      case (alucontrol)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_bit};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_reg_unit.sv
// Multicycle-MIPS execution primitives: ALU, ALUOut register (loads every
// cycle) and a general enabled register for PC/IR-style state.
module alu_reg_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_reg_unit_if.slave bus
);

   logic [WIDTH-1:0] aluresult;
   logic             zero;
   logic [WIDTH-1:0] aluout_r;
   logic [WIDTH-1:0] q_r;

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .a          (bus.srca),
      .b          (bus.srcb),
      .alucontrol (bus.alucontrol),
      .result     (aluresult),
      .zero       (zero)
   );

   always_ff @(posedge clk) begin
      if (reset) aluout_r <= '0;
      else       aluout_r <= aluresult;
   end

   // Reset takes priority over the load enable.
   always_ff @(posedge clk) begin
      if (reset)       q_r <= '0;
      else if (bus.en) q_r <= bus.d;
   end

   assign bus.aluresult = aluresult;
   assign bus.zero      = zero;
   assign bus.aluout    = aluout_r;
   assign bus.q         = q_r;

endmodule

// File: tb/tb_alu_reg_unit.sv
// Scoreboard bench for alu_reg_unit: stimulus queues each directed vector with
// its hand-computed expectations; a monitor compares at every falling edge.
module tb_alu_reg_unit;
   import mips_pkg::*;

   localparam int WIDTH = 32;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        en;
      logic [31:0] d;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic        chk_reg;
      logic [31:0] exp_out;
      logic [31:0] exp_q;
   } vec_t;

   logic clk;
   logic reset;
   alu_reg_unit_if #(.WIDTH(WIDTH)) bus ();

   alu_reg_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(string name, logic rst, logic [3:0] op,
                               logic [31:0] a, logic [31:0] b, logic en,
                               logic [31:0] d, logic [31:0] exp_res,
                               logic exp_zero, logic chk_reg,
                               logic [31:0] exp_out, logic [31:0] exp_q);
      vec_t v;
      v.name = name; v.rst = rst; v.op = op; v.a = a; v.b = b; v.en = en;
      v.d = d; v.exp_res = exp_res; v.exp_zero = exp_zero;
      v.chk_reg = chk_reg; v.exp_out = exp_out; v.exp_q = exp_q;
      vecs.push_back(v);
   endfunction

   // Inputs of vector i are latched at the rising edge after its check, so
   // exp_out/exp_q of vector i reflect vector i-1.
   initial begin
      //   name              rst op        a             b             en d             res           z  chk out           q
      add("rst_hold0",      1, ALU_ADD,  32'd2,        32'd3,        0, 32'h0,        32'd5,        0, 0, 32'h0,        32'h0);
      add("rst_hold1",      1, ALU_ADD,  32'd2,        32'd3,        1, 32'h55,       32'd5,        0, 1, 32'h0,        32'h0);
      add("add_ovf",        0, ALU_ADD,  32'h7FFFFFFF, 32'h1,        1, 32'h1234,     32'h80000000, 0, 1, 32'h0,        32'h0);
      add("sub_eq",         0, ALU_SUB,  32'd5,        32'd5,        0, 32'hABCD,     32'h0,        1, 1, 32'h80000000, 32'h1234);
      add("and",            0, ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hABCD,     32'hF000F000, 0, 1, 32'h0,        32'h1234);
      add("or",             0, ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hABCD,     32'hFFF0FFF0, 0, 1, 32'hF000F000, 32'h1234);
      add("slt_neg",        0, ALU_SLT,  32'hFFFFFFFF, 32'h1,        0, 32'h0,        32'h1,        0, 1, 32'hFFF0FFF0, 32'h1234);
      add("sltu_big",       0, ALU_SLTU, 32'hFFFFFFFF, 32'h1,        0, 32'h0,        32'h0,        1, 1, 32'h1,        32'h1234);
      add("slt_ovf",        0, ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 0, 32'h0,        32'h1,        0, 1, 32'h0,        32'h1234);
      add("slt_equal",      0, ALU_SLT,  32'd3,        32'd3,        0, 32'h0,        32'h0,        1, 1, 32'h1,        32'h1234);
      add("unlisted_0101",  0, 4'b0101,  32'd7,        32'd9,        0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h1234);
      add("sub_neg",        0, ALU_SUB,  32'd3,        32'd4,        0, 32'h0,        32'hFFFFFFFF, 0, 1, 32'h0,        32'h1234);
      add("add_before_edge",0, ALU_ADD,  32'd2,        32'd3,        0, 32'h0,        32'd5,        0, 1, 32'hFFFFFFFF, 32'h1234);
      add("rst_mid",        1, ALU_ADD,  32'd2,        32'd3,        1, 32'h9999,     32'd5,        0, 1, 32'd5,        32'h1234);
      add("after_rst",      0, ALU_ADD,  32'd2,        32'd3,        0, 32'h0,        32'd5,        0, 1, 32'h0,        32'h0);
      add("sltu_small",     0, ALU_SLTU, 32'd1,        32'd2,        1, 32'hCAFE,     32'h1,        0, 1, 32'd5,        32'h0);
      add("rst_live_alu",   1, ALU_OR,   32'h0F,       32'hF0,       0, 32'h0,        32'hFF,       0, 1, 32'h1,        32'hCAFE);
      add("and_zero",       0, ALU_AND,  32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0);
      add("slt_pos_vs_neg", 0, ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0);
      add("unlisted_1000",  0, 4'b1000,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0);
      add("add_wrap",       0, ALU_ADD,  32'hFFFFFFFF, 32'h2,        0, 32'h0,        32'h1,        0, 1, 32'h0,        32'h0);
      add("final_regs",     0, ALU_OR,   32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 1, 32'h1,        32'h0);

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         bus.alucontrol = vecs[i].op;
         bus.srca       = vecs[i].a;
         bus.srcb       = vecs[i].b;
         bus.en         = vecs[i].en;
         bus.d          = vecs[i].d;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
      end

      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.aluresult !== e.exp_res) begin
               errors++;
               $display("FAIL %s aluresult: got %h, required %h", e.name, bus.aluresult, e.exp_res);
            end
            checks++;
            if (bus.zero !== e.exp_zero) begin
               errors++;
               $display("FAIL %s zero: got %b, required %b", e.name, bus.zero, e.exp_zero);
            end
            if (e.chk_reg) begin
               checks++;
               if (bus.aluout !== e.exp_out) begin
                  errors++;
                  $display("FAIL %s aluout: got %h, required %h", e.name, bus.aluout, e.exp_out);
               end
               checks++;
               if (bus.q !== e.exp_q) begin
                  errors++;
                  $display("FAIL %s q: got %h, required %h", e.name, bus.q, e.exp_q);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
